writeback_unit: RTL and testbench



---
 rtl/writeback_unit_if.sv | 38 +++
 rtl/writeback_unit.sv | 172 +++++++++++++++++
 tb/tb_writeback_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Execute -> writeback -> register-file bundle, plus the data-memory load port.
// The unit itself uses the slave view; execute/memory/regfile models use master.
interface writeback_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [1:0]      ex_wb_sel;
  logic [2:0]      ex_funct3;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  logic            load_err;
  logic            reg_wr;
  logic [4:0]      reg_wr_addr;
  logic [XLEN-1:0] reg_wr_data;

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_pc_plus4, ex_wb_sel, ex_funct3,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    output ex_ready, dmem_req_valid, dmem_addr, load_err,
    output reg_wr, reg_wr_addr, reg_wr_data
  );

  modport master (
    output ex_valid, ex_rd, ex_result, ex_pc_plus4, ex_wb_sel, ex_funct3,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    input  ex_ready, dmem_req_valid, dmem_addr, load_err,
    input  reg_wr, reg_wr_addr, reg_wr_data
  );
endinterface

// File: rtl/writeback_unit.sv
// RV32I writeback stage: retires ALU/link results directly and performs
// single outstanding data loads with byte/half alignment and extension.
module writeback_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t          r_state;
    state_t          w_next;

    logic [4:0]      r_rd;
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;

    logic            r_reg_wr;
    logic [4:0]      r_reg_wr_addr;
    logic [XLEN-1:0] r_reg_wr_data;
    logic            r_load_err;

    logic            w_ready;
    logic            w_accept;
    logic            w_legal;
    logic            w_wr;
    logic            w_err;
    logic [4:0]      w_wr_addr;
    logic [XLEN-1:0] w_wr_data;
    logic [XLEN-1:0] w_load_data;

    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~off[0];
            F3_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_LB:   v = {{24{b[7]}}, b};
            F3_LH:   v = {{16{h[15]}}, h};
            F3_LBU:  v = {24'h000000, b};
            F3_LHU:  v = {16'h0000, h};
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Gated by rst so ex_ready reads 0 while reset is held, even though state is IDLE.
    assign w_ready     = (r_state == IDLE) && !rst;
    assign w_accept    = bus.ex_valid && w_ready;
    assign w_legal     = load_legal(bus.ex_funct3, bus.ex_result[1:0]);
    assign w_load_data = load_extract(r_funct3, r_off, bus.dmem_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_wr      = 1'b0;
        w_err     = 1'b0;
        w_wr_addr = r_reg_wr_addr;
        w_wr_data = r_reg_wr_data;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (bus.ex_wb_sel)
                        WB_ALU, WB_PC4: begin
                            if (bus.ex_rd != 5'd0) begin
                                w_wr      = 1'b1;
                                w_wr_addr = bus.ex_rd;
                                w_wr_data = (bus.ex_wb_sel == WB_PC4) ? bus.ex_pc_plus4
                                                                      : bus.ex_result;
                            end
                        end
                        WB_LOAD: begin
                            if (w_legal) begin
                                w_next = MEM_REQ;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MEM_REQ: begin
                if (bus.dmem_req_ready) begin
                    w_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_rsp_valid) begin
                    w_next = IDLE;
                    if (r_rd != 5'd0) begin
                        w_wr      = 1'b1;
                        w_wr_addr = r_rd;
                        w_wr_data = w_load_data;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd          <= '0;
            r_off         <= '0;
            r_funct3      <= '0;
            r_addr        <= '0;
            r_reg_wr      <= 1'b0;
            r_reg_wr_addr <= '0;
            r_reg_wr_data <= '0;
            r_load_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd     <= bus.ex_rd;
                r_off    <= bus.ex_result[1:0];
                r_funct3 <= bus.ex_funct3;
                r_addr   <= {bus.ex_result[XLEN-1:2], 2'b00};
            end
            r_reg_wr      <= w_wr;
            r_reg_wr_addr <= w_wr_addr;
            r_reg_wr_data <= w_wr_data;
            r_load_err    <= w_err;
        end
    end

    assign bus.ex_ready       = w_ready;
    assign bus.dmem_req_valid = (r_state == MEM_REQ);
    assign bus.dmem_addr      = r_addr;
    assign bus.load_err       = r_load_err;
    assign bus.reg_wr         = r_reg_wr;
    assign bus.reg_wr_addr    = r_reg_wr_addr;
    assign bus.reg_wr_data    = r_reg_wr_data;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU/link retirement, load extraction,
// memory stalls, illegal loads and reset in the middle of a load.
module tb_writeback_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    writeback_unit_if #(.XLEN(32)) bus ();

    writeback_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid       = 1'b0;
        bus.ex_rd          = '0;
        bus.ex_result      = '0;
        bus.ex_pc_plus4    = '0;
        bus.ex_wb_sel      = 2'b11;
        bus.ex_funct3      = '0;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rdata     = '0;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] res,
                            input logic [31:0] pc4, input logic [2:0] f3);
        bus.ex_valid    = 1'b1;
        bus.ex_rd       = rd;
        bus.ex_wb_sel   = sel;
        bus.ex_result   = res;
        bus.ex_pc_plus4 = pc4;
        bus.ex_funct3   = f3;
    endtask

    // Zero-wait load: request accepted the first cycle, response the cycle after.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] ea, input logic [31:0] rdata,
                           input logic [31:0] exp, input logic exp_wr);
        drive_op(rd, 2'b01, ea, 32'h0, f3);
        step();
        bus.ex_valid = 1'b0;
        check({tag, "_reqv"}, bus.dmem_req_valid, 32'd1);
        check({tag, "_addr"}, bus.dmem_addr, 32'h0000_1000);
        check({tag, "_rdy0"}, bus.ex_ready, 32'd0);
        bus.dmem_req_ready = 1'b1;
        step();
        bus.dmem_req_ready = 1'b0;
        check({tag, "_reqv_drop"}, bus.dmem_req_valid, 32'd0);
        check({tag, "_nowr_wait"}, bus.reg_wr, 32'd0);
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rdata     = rdata;
        step();
        bus.dmem_rsp_valid = 1'b0;
        check({tag, "_wr"}, bus.reg_wr, {31'd0, exp_wr});
        if (exp_wr) begin
            check({tag, "_wa"}, bus.reg_wr_addr, {27'd0, rd});
            check({tag, "_wd"}, bus.reg_wr_data, exp);
        end
        step();
        check({tag, "_wr_end"}, bus.reg_wr, 32'd0);
        check({tag, "_rdy1"}, bus.ex_ready, 32'd1);
    endtask

    task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] ea);
        drive_op(5'd3, 2'b01, ea, 32'h0, f3);
        step();
        bus.ex_valid = 1'b0;
        check({tag, "_err"}, bus.load_err, 32'd1);
        check({tag, "_reqv"}, bus.dmem_req_valid, 32'd0);
        check({tag, "_wr"}, bus.reg_wr, 32'd0);
        check({tag, "_rdy"}, bus.ex_ready, 32'd1);
        step();
        check({tag, "_err_end"}, bus.load_err, 32'd0);
        check({tag, "_reqv_end"}, bus.dmem_req_valid, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        repeat (3) step();

        check("rst_ready", bus.ex_ready, 32'd0);
        check("rst_reqv", bus.dmem_req_valid, 32'd0);
        check("rst_addr", bus.dmem_addr, 32'd0);
        check("rst_err", bus.load_err, 32'd0);
        check("rst_wr", bus.reg_wr, 32'd0);
        check("rst_wa", bus.reg_wr_addr, 32'd0);
        check("rst_wd", bus.reg_wr_data, 32'd0);

        rst = 1'b0;
        #1;
        check("alu_ready", bus.ex_ready, 32'd1);
        drive_op(5'd5, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000);
        step();
        bus.ex_valid = 1'b0;
        check("alu_wr", bus.reg_wr, 32'd1);
        check("alu_wa", bus.reg_wr_addr, 32'd5);
        check("alu_wd", bus.reg_wr_data, 32'hDEAD_BEEF);
        step();
        check("alu_wr_end", bus.reg_wr, 32'd0);

        drive_op(5'd1, 2'b10, 32'h0000_0055, 32'h0000_0104, 3'b000);
        step();
        check("b2b1_wr", bus.reg_wr, 32'd1);
        check("b2b1_wa", bus.reg_wr_addr, 32'd1);
        check("b2b1_wd", bus.reg_wr_data, 32'h0000_0104);
        check("b2b1_rdy", bus.ex_ready, 32'd1);
        drive_op(5'd2, 2'b00, 32'h0000_0007, 32'h0000_0108, 3'b000);
        step();
        check("b2b2_wr", bus.reg_wr, 32'd1);
        check("b2b2_wa", bus.reg_wr_addr, 32'd2);
        check("b2b2_wd", bus.reg_wr_data, 32'h0000_0007);
        check("b2b2_rdy", bus.ex_ready, 32'd1);
        drive_op(5'd0, 2'b00, 32'h0000_0009, 32'h0000_010C, 3'b000);
        step();
        bus.ex_valid = 1'b0;
        check("b2b3_nowr", bus.reg_wr, 32'd0);
        check("b2b3_rdy", bus.ex_ready, 32'd1);

        drive_op(5'd6, 2'b11, 32'h1111_1111, 32'h2222_2222, 3'b000);
        step();
        bus.ex_valid = 1'b0;
        check("nowb_wr", bus.reg_wr, 32'd0);
        check("nowb_rdy", bus.ex_ready, 32'd1);

        do_load("lb0",  3'b000, 5'd10, 32'h0000_1000, 32'h807F_C3A5, 32'hFFFF_FFA5, 1'b1);
        do_load("lbu1", 3'b100, 5'd11, 32'h0000_1001, 32'h807F_C3A5, 32'h0000_00C3, 1'b1);
        do_load("lb3",  3'b000, 5'd12, 32'h0000_1003, 32'h807F_C3A5, 32'hFFFF_FF80, 1'b1);
        do_load("lh2",  3'b001, 5'd13, 32'h0000_1002, 32'h807F_C3A5, 32'hFFFF_807F, 1'b1);
        do_load("lhu2", 3'b101, 5'd14, 32'h0000_1002, 32'h807F_C3A5, 32'h0000_807F, 1'b1);
        do_load("lh0",  3'b001, 5'd15, 32'h0000_1000, 32'h807F_C3A5, 32'hFFFF_C3A5, 1'b1);
        do_load("lw0",  3'b010, 5'd16, 32'h0000_1000, 32'h807F_C3A5, 32'h807F_C3A5, 1'b1);
        do_load("lw_x0", 3'b010, 5'd0, 32'h0000_1000, 32'h807F_C3A5, 32'h0, 1'b0);

        // Stalled request, response coincident with the request edge, then a late response.
        drive_op(5'd20, 2'b01, 32'h0000_2000, 32'h0, 3'b010);
        step();
        bus.ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_reqv", bus.dmem_req_valid, 32'd1);
            check("stall_addr", bus.dmem_addr, 32'h0000_2000);
            check("stall_rdy", bus.ex_ready, 32'd0);
            step();
        end
        bus.dmem_req_ready = 1'b1;
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rdata     = 32'h0BAD_0BAD;
        step();
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("delay_nowr", bus.reg_wr, 32'd0);
            check("delay_rdy", bus.ex_ready, 32'd0);
            step();
        end
        check("delay_nowr_last", bus.reg_wr, 32'd0);
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rdata     = 32'h1234_5678;
        step();
        bus.dmem_rsp_valid = 1'b0;
        check("delay_wr", bus.reg_wr, 32'd1);
        check("delay_wa", bus.reg_wr_addr, 32'd20);
        check("delay_wd", bus.reg_wr_data, 32'h1234_5678);
        step();
        check("delay_wr_end", bus.reg_wr, 32'd0);

        bad_load("err_lw",  3'b010, 32'h0000_1002);
        bad_load("err_lh",  3'b001, 32'h0000_1001);
        bad_load("err_f3",  3'b011, 32'h0000_1000);
        bad_load("err_lhu", 3'b101, 32'h0000_1003);

        // Reset while waiting for a response; the late response must be dropped.
        drive_op(5'd9, 2'b01, 32'h0000_3000, 32'h0, 3'b010);
        step();
        bus.ex_valid       = 1'b0;
        bus.dmem_req_ready = 1'b1;
        step();
        bus.dmem_req_ready = 1'b0;
        check("mid_wait_rdy", bus.ex_ready, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", bus.ex_ready, 32'd0);
        check("mid_rst_reqv", bus.dmem_req_valid, 32'd0);
        check("mid_rst_addr", bus.dmem_addr, 32'd0);
        check("mid_rst_wr", bus.reg_wr, 32'd0);
        step();
        step();
        rst = 1'b0;
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rdata     = 32'hCAFE_F00D;
        step();
        bus.dmem_rsp_valid = 1'b0;
        check("late_rsp_nowr", bus.reg_wr, 32'd0);
        check("late_rsp_rdy", bus.ex_ready, 32'd1);
        drive_op(5'd7, 2'b00, 32'h0000_0055, 32'h0, 3'b000);
        step();
        bus.ex_valid = 1'b0;
        check("post_rst_wr", bus.reg_wr, 32'd1);
        check("post_rst_wa", bus.reg_wr_addr, 32'd7);
        check("post_rst_wd", bus.reg_wr_data, 32'h0000_0055);
        step();
        check("post_rst_wr_end", bus.reg_wr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
